// File: rtl/traffic_safety_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers.
// Passes lamp codes through, or latches a fault and flashes yellow.
module traffic_safety_monitor #(
    parameter int unsigned MAX_GREEN  = 8,
    parameter int unsigned MAX_YELLOW = 2,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       sec_clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [1:0] north_in,
    input  logic [1:0] east_in,
    input  logic [1:0] south_in,
    input  logic [1:0] west_in,
    output logic [1:0] north_out,
    output logic [1:0] east_out,
    output logic [1:0] south_out,
    output logic [1:0] west_out,
    output logic       fault,
    output logic [2:0] fault_code
);

    typedef enum logic {
        MONITOR,
        FAULT
    } state_t;

    localparam logic [1:0] LAMP_DARK   = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;

    localparam logic [2:0] CODE_NONE   = 3'd0;
    localparam logic [2:0] CODE_DARK   = 3'd1;
    localparam logic [2:0] CODE_MULTI  = 3'd2;
    localparam logic [2:0] CODE_SEQ    = 3'd3;
    localparam logic [2:0] CODE_GREEN  = 3'd4;
    localparam logic [2:0] CODE_YELLOW = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONES  = '1;
    localparam logic [CNT_W-1:0] GREEN_LIM = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] YEL_LIM   = CNT_W'(MAX_YELLOW);

    state_t           state_q, state_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] grn_cnt_q, grn_cnt_d;
    logic [CNT_W-1:0] yel_cnt_q, yel_cnt_d;
    logic             lg_valid_q, lg_valid_d;
    logic [1:0]       last_green_q, last_green_d;

    logic [3:0][1:0]  lamps;
    logic             any_dark;
    logic             any_yel;
    logic [2:0]       n_green;
    logic [1:0]       g_dir;

    logic             one_green;
    logic             multi_green;
    logic             same_green;
    logic             seq_bad;
    logic             grn_bad;
    logic             yel_run;
    logic             yel_bad;
    logic             clear_ok;
    logic [2:0]       cause;
    logic [CNT_W-1:0] grn_inc;
    logic [CNT_W-1:0] yel_inc;
    logic [1:0]       flash;

    assign lamps = {west_in, south_in, east_in, north_in};

    // Summarise the four lamp codes: dark, yellow, green count and direction.
    always_comb begin
        any_dark = 1'b0;
        any_yel  = 1'b0;
        n_green  = 3'd0;
        g_dir    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (lamps[i] == LAMP_DARK) begin
                any_dark = 1'b1;
            end
            if (lamps[i] == LAMP_YELLOW) begin
                any_yel = 1'b1;
            end
            if (lamps[i] == LAMP_GREEN) begin
                n_green = n_green + 3'd1;
                g_dir   = 2'(i);
            end
        end
    end

    // Violation checks and the highest-priority cause.
    always_comb begin
        one_green   = (n_green == 3'd1);
        multi_green = (n_green >= 3'd2);
        // A nonzero green count means the previous sample held exactly
        // one green, and last_green records which direction it was.
        same_green  = one_green && lg_valid_q &&
                      (grn_cnt_q != CNT_ZERO) &&
                      (last_green_q == g_dir);
        seq_bad     = one_green && !same_green && lg_valid_q &&
                      (g_dir != last_green_q + 2'd1);
        grn_bad     = same_green && (grn_cnt_q >= GREEN_LIM);
        yel_run     = (n_green == 3'd0) && any_yel;
        yel_bad     = yel_run && (yel_cnt_q >= YEL_LIM);
        clear_ok    = !any_dark && !multi_green;
        grn_inc     = (grn_cnt_q == CNT_ONES) ? grn_cnt_q
                                              : grn_cnt_q + CNT_ONE;
        yel_inc     = (yel_cnt_q == CNT_ONES) ? yel_cnt_q
                                              : yel_cnt_q + CNT_ONE;
        if (any_dark) begin
            cause = CODE_DARK;
        end else if (multi_green) begin
            cause = CODE_MULTI;
        end else if (seq_bad) begin
            cause = CODE_SEQ;
        end else if (grn_bad) begin
            cause = CODE_GREEN;
        end else if (yel_bad) begin
            cause = CODE_YELLOW;
        end else begin
            cause = CODE_NONE;
        end
    end

    // Next-state logic: track phases in MONITOR, flash and await clear in FAULT.
    always_comb begin
        state_d      = state_q;
        fault_d      = fault_q;
        code_d       = code_q;
        phase_d      = phase_q;
        grn_cnt_d    = grn_cnt_q;
        yel_cnt_d    = yel_cnt_q;
        lg_valid_d   = lg_valid_q;
        last_green_d = last_green_q;
        unique case (state_q)
            MONITOR: begin
                if (cause != CODE_NONE) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    code_d  = cause;
                    phase_d = 1'b0;
                end else begin
                    if (one_green) begin
                        if (same_green) begin
                            grn_cnt_d = grn_inc;
                        end else begin
                            grn_cnt_d    = CNT_ONE;
                            last_green_d = g_dir;
                            lg_valid_d   = 1'b1;
                        end
                    end else begin
                        grn_cnt_d = CNT_ZERO;
                    end
                    yel_cnt_d = yel_run ? yel_inc : CNT_ZERO;
                end
            end
            FAULT: begin
                if (clear && clear_ok) begin
                    state_d    = MONITOR;
                    fault_d    = 1'b0;
                    code_d     = CODE_NONE;
                    phase_d    = 1'b0;
                    grn_cnt_d  = CNT_ZERO;
                    yel_cnt_d  = CNT_ZERO;
                    lg_valid_d = 1'b0;
                end else begin
                    phase_d = ~phase_q;
                end
            end
            default: begin
                state_d = MONITOR;
            end
        endcase
    end

    // State and registered status flops.
    always_ff @(posedge sec_clock or posedge reset) begin
        if (reset) begin
            state_q      <= MONITOR;
            fault_q      <= 1'b0;
            code_q       <= CODE_NONE;
            phase_q      <= 1'b0;
            grn_cnt_q    <= CNT_ZERO;
            yel_cnt_q    <= CNT_ZERO;
            lg_valid_q   <= 1'b0;
            last_green_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            phase_q      <= phase_d;
            grn_cnt_q    <= grn_cnt_d;
            yel_cnt_q    <= yel_cnt_d;
            lg_valid_q   <= lg_valid_d;
            last_green_q <= last_green_d;
        end
    end

    // Lamp drive: pass-through in MONITOR, yellow/dark flash in FAULT.
    always_comb begin
        flash = phase_q ? LAMP_DARK : LAMP_YELLOW;
        if (state_q == FAULT) begin
            north_out = flash;
            east_out  = flash;
            south_out = flash;
            west_out  = flash;
        end else begin
            north_out = north_in;
            east_out  = east_in;
            south_out = south_in;
            west_out  = west_in;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Bench for traffic_safety_monitor: run-length reference model
// checked every cycle, plus directed literal expectations.
module tb_traffic_safety_monitor;

    localparam int MAX_GREEN  = 8;
    localparam int MAX_YELLOW = 2;

    localparam logic [1:0] D = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] R = 2'b11;

    logic       sec_clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [1:0] north_in = R;
    logic [1:0] east_in = R;
    logic [1:0] south_in = R;
    logic [1:0] west_in = R;
    logic [1:0] north_out, east_out, south_out, west_out;
    logic       fault;
    logic [2:0] fault_code;

    int total = 0;
    int bad = 0;

    // Reference model state, in plain run-length terms.
    int m_fault = 0;
    int m_code = 0;
    int m_phase = 0;
    int m_grun = 0;
    int m_gdir = -1;
    int m_last = -1;
    int m_yrun = 0;

    int ng, gd, cs;
    bit dk, yl, cont;
    logic [1:0] v [4];

    traffic_safety_monitor #(
        .MAX_GREEN(MAX_GREEN),
        .MAX_YELLOW(MAX_YELLOW),
        .CNT_W(4)
    ) dut (
        .sec_clock(sec_clock),
        .reset(reset),
        .clear(clear),
        .north_in(north_in),
        .east_in(east_in),
        .south_in(south_in),
        .west_in(west_in),
        .north_out(north_out),
        .east_out(east_out),
        .south_out(south_out),
        .west_out(west_out),
        .fault(fault),
        .fault_code(fault_code)
    );

    always #5 sec_clock = ~sec_clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    // Model update at each tick.
    always @(posedge sec_clock or posedge reset) begin
        if (reset) begin
            m_fault = 0; m_code = 0; m_phase = 0;
            m_grun = 0; m_gdir = -1; m_last = -1; m_yrun = 0;
        end else begin
            v[0] = north_in; v[1] = east_in;
            v[2] = south_in; v[3] = west_in;
            ng = 0; gd = -1; dk = 0; yl = 0;
            for (int i = 0; i < 4; i++) begin
                if (v[i] == D) dk = 1;
                if (v[i] == Y) yl = 1;
                if (v[i] == G) begin ng++; gd = i; end
            end
            if (m_fault == 0) begin
                cont = (ng == 1) && (gd == m_gdir) && (m_grun > 0);
                cs = 0;
                if (dk) cs = 1;
                else if (ng >= 2) cs = 2;
                else if (ng == 1 && !cont && m_last >= 0 &&
                         gd != (m_last + 1) % 4) cs = 3;
                else if (cont && m_grun + 1 > MAX_GREEN) cs = 4;
                else if (ng == 0 && yl && m_yrun + 1 > MAX_YELLOW) cs = 5;
                if (cs != 0) begin
                    m_fault = 1; m_code = cs; m_phase = 0;
                end else begin
                    if (ng == 1) begin
                        if (cont) m_grun++;
                        else begin m_grun = 1; m_gdir = gd; m_last = gd; end
                    end else begin
                        m_grun = 0; m_gdir = -1;
                    end
                    m_yrun = (ng == 0 && yl) ? m_yrun + 1 : 0;
                end
            end else if (clear && !dk && ng <= 1) begin
                m_fault = 0; m_code = 0; m_phase = 0;
                m_grun = 0; m_gdir = -1; m_last = -1; m_yrun = 0;
            end else begin
                m_phase ^= 1;
            end
        end
    end

    function automatic int want_out(input logic [1:0] inp);
        if (m_fault != 0) return (m_phase != 0) ? 0 : 2;
        return int'(inp);
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge sec_clock) begin
        if (!reset) begin
            check("fault", int'(fault), m_fault);
            check("code", int'(fault_code), m_code);
            check("n_out", int'(north_out), want_out(north_in));
            check("e_out", int'(east_out), want_out(east_in));
            check("s_out", int'(south_out), want_out(south_in));
            check("w_out", int'(west_out), want_out(west_in));
        end
    end

    task automatic apply(input logic [1:0] n, e, s, w, input logic clr);
        north_in = n; east_in = e; south_in = s; west_in = w;
        clear = clr;
        @(posedge sec_clock);
        #2;
    endtask

    task automatic lamps(input int g, y0, y1, input logic clr);
        logic [1:0] p [4];
        for (int i = 0; i < 4; i++)
            p[i] = (i == g) ? G : ((i == y0 || i == y1) ? Y : R);
        apply(p[0], p[1], p[2], p[3], clr);
    endtask

    initial begin
        #3;
        check("rst_fault", int'(fault), 0);
        check("rst_code", int'(fault_code), 0);
        check("rst_pass", int'(north_out), int'(R));
        @(posedge sec_clock);
        #2;
        reset = 1'b0;

        // Normal cycle: two N-E-S-W loops, clear held high on the second.
        for (int lp = 0; lp < 2; lp++) begin
            for (int d = 0; d < 4; d++) begin
                for (int k = 0; k < 6; k++) lamps(d, -1, -1, lp == 1);
                lamps(-1, d, (d + 1) % 4, lp == 1);
            end
        end
        check("normal_fault", int'(fault), 0);

        // Double green.
        apply(G, G, R, R, 1'b0);
        check("dbl_fault", int'(fault), 1);
        check("dbl_code", int'(fault_code), 2);
        check("dbl_flash0", int'(east_out), int'(Y));
        apply(R, R, R, R, 1'b0);
        check("dbl_flash1", int'(west_out), int'(D));
        apply(R, R, R, R, 1'b0);
        check("dbl_flash2", int'(south_out), int'(Y));
        apply(R, R, R, R, 1'b1);
        check("dbl_clear", int'(fault), 0);

        // Sequence skip N -> S.
        lamps(0, -1, -1, 0);
        lamps(0, -1, -1, 0);
        lamps(-1, 0, -1, 0);
        lamps(2, -1, -1, 0);
        check("seq_code", int'(fault_code), 3);
        apply(R, R, R, R, 1'b1);
        check("seq_clear", int'(fault), 0);
        check("seq_pass", int'(north_out), int'(R));

        // Green timeout on the ninth tick.
        for (int k = 0; k < 8; k++) lamps(0, -1, -1, 0);
        check("gto_8", int'(fault), 0);
        lamps(0, -1, -1, 0);
        check("gto_9", int'(fault), 1);
        check("gto_code", int'(fault_code), 4);

        // Clear coincides with an out-of-order green: clear wins.
        lamps(2, -1, -1, 1);
        check("clr_win", int'(fault), 0);
        check("clr_pass", int'(south_out), int'(G));
        lamps(2, -1, -1, 0);
        check("fresh_seq", int'(fault), 0);
        lamps(-1, 2, -1, 0);
        lamps(-1, -1, -1, 0);

        // Yellow timeout, then an illegal clear.
        lamps(-1, 0, -1, 0);
        lamps(-1, 0, -1, 0);
        check("yto_2", int'(fault), 0);
        lamps(-1, 0, -1, 0);
        check("yto_code", int'(fault_code), 5);
        apply(R, R, R, D, 1'b1);
        check("bad_clr", int'(fault), 1);
        check("bad_clr_code", int'(fault_code), 5);
        apply(R, R, R, R, 1'b1);
        check("yto_clear", int'(fault), 0);

        // Async reset mid-fault.
        lamps(0, -1, -1, 0);
        apply(D, R, R, R, 1'b0);
        check("dark_code", int'(fault_code), 1);
        apply(R, G, R, R, 1'b0);
        reset = 1'b1;
        #1;
        check("ar_fault", int'(fault), 0);
        check("ar_code", int'(fault_code), 0);
        check("ar_pass", int'(east_out), int'(G));
        reset = 1'b0;
        lamps(2, -1, -1, 0);
        check("ar_any_dir", int'(fault), 0);
        lamps(2, -1, -1, 0);
        lamps(-1, 2, -1, 0);

        @(negedge sec_clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
